// File: rtl/hazard_unit_fwd_stall.sv
// Hazard unit: execute operand forwarding selects, load-use stall FSM
// and a saturating stall-cycle counter.
module hazard_unit_fwd_stall #(
    parameter int N        = 4,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_EN  = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NSRC*N-1:0]   Reg_D,
    input  logic [NSRC-1:0]     Use_D,
    input  logic [NSRC*N-1:0]   Reg_E,
    input  logic [N-1:0]        Rd_E,
    input  logic                We_E,
    input  logic                Ld_E,
    input  logic [N-1:0]        Rd_M,
    input  logic                We_M,
    input  logic [N-1:0]        Rd_WB,
    input  logic                We_WB,
    input  logic                Flush_In,
    input  logic                Clr_Cnt,
    output logic [2*NSRC-1:0]   S_Hazard,
    output logic                Stall_F,
    output logic                Stall_D,
    output logic                Flush_E,
    output logic [CNT_W-1:0]    Stall_Cnt
);

    localparam int LW = $clog2(LOAD_LAT + 1);
    localparam logic [LW-1:0] CNT_INIT = LW'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t          state;
    logic [LW-1:0]   cnt;
    logic [2*NSRC-1:0] sel;
    logic            hit;
    logic            stall;
    logic            flush;

    always_comb begin
        logic [N-1:0] r;
        logic         z;
        sel = '0;
        r   = '0;
        z   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            r = Reg_E[i*N +: N];
            z = (ZERO_EN != 0) && (r == '0);
            if (We_M && Rd_M == r && !z)
                sel[2*i +: 2] = 2'b01;
            else if (We_WB && Rd_WB == r && !z)
                sel[2*i +: 2] = 2'b10;
        end
    end

    always_comb begin
        logic any;
        any = 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (Use_D[i] && Reg_D[i*N +: N] == Rd_E)
                any = 1'b1;
        hit = any && Ld_E && We_E && !((ZERO_EN != 0) && (Rd_E == '0));
    end

    // Mealy outputs: a hit stalls in the very cycle it is detected
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        unique case (state)
            IDLE: begin
                if (Flush_In) begin
                    flush = 1'b1;
                end else if (hit) begin
                    stall = 1'b1;
                    flush = 1'b1;
                end
            end
            STALL: begin
                flush = 1'b1;
                stall = !Flush_In;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!Flush_In && hit && LOAD_LAT > 1) begin
                        state <= STALL;
                        cnt   <= CNT_INIT;
                    end
                end
                STALL: begin
                    if (Flush_In || cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            Stall_Cnt <= '0;
        else if (Clr_Cnt)
            Stall_Cnt <= '0;
        else if (stall && Stall_Cnt != '1)
            Stall_Cnt <= Stall_Cnt + 1'b1;
    end

    // Outputs are gated so reset silences them without waiting for a clock
    assign S_Hazard = rst_n ? sel : '0;
    assign Stall_F  = rst_n & stall;
    assign Stall_D  = rst_n & stall;
    assign Flush_E  = rst_n & flush;

endmodule

// File: tb/tb_hazard_unit_fwd_stall.sv
// Scoreboard bench for hazard_unit_fwd_stall: directed scenarios plus
// randomized traffic against a remaining-stall-cycles reference model.
module tb_hazard_unit_fwd_stall;

    localparam int N        = 4;
    localparam int NSRC     = 2;
    localparam int LOAD_LAT = 3;
    localparam int ZERO_EN  = 1;
    localparam int CNT_W    = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NSRC*N-1:0]   Reg_D = '0;
    logic [NSRC-1:0]     Use_D = '0;
    logic [NSRC*N-1:0]   Reg_E = '0;
    logic [N-1:0]        Rd_E = '0;
    logic                We_E = 1'b0;
    logic                Ld_E = 1'b0;
    logic [N-1:0]        Rd_M = '0;
    logic                We_M = 1'b0;
    logic [N-1:0]        Rd_WB = '0;
    logic                We_WB = 1'b0;
    logic                Flush_In = 1'b0;
    logic                Clr_Cnt = 1'b0;
    logic [2*NSRC-1:0]   S_Hazard;
    logic                Stall_F;
    logic                Stall_D;
    logic                Flush_E;
    logic [CNT_W-1:0]    Stall_Cnt;

    hazard_unit_fwd_stall #(
        .N(N), .NSRC(NSRC), .LOAD_LAT(LOAD_LAT),
        .ZERO_EN(ZERO_EN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .Reg_D(Reg_D), .Use_D(Use_D), .Reg_E(Reg_E),
        .Rd_E(Rd_E), .We_E(We_E), .Ld_E(Ld_E),
        .Rd_M(Rd_M), .We_M(We_M), .Rd_WB(Rd_WB), .We_WB(We_WB),
        .Flush_In(Flush_In), .Clr_Cnt(Clr_Cnt),
        .S_Hazard(S_Hazard), .Stall_F(Stall_F), .Stall_D(Stall_D),
        .Flush_E(Flush_E), .Stall_Cnt(Stall_Cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*NSRC-1:0] sh;
        logic              sf;
        logic              sd;
        logic              fe;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mrem = 0;
    int   mcnt = 0;
    bit   done = 0;

    function automatic logic [1:0] ref_fwd(input logic [N-1:0] r);
        if (ZERO_EN != 0 && r == 0) return 2'b00;
        if (We_M && Rd_M == r) return 2'b01;
        if (We_WB && Rd_WB == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ref_hit();
        if (!(Ld_E && We_E)) return 0;
        if (ZERO_EN != 0 && Rd_E == 0) return 0;
        for (int i = 0; i < NSRC; i++)
            if (Use_D[i] && Reg_D[i*N +: N] == Rd_E) return 1;
        return 0;
    endfunction

    // Expected outputs for the current cycle, then advance model to next edge
    task automatic expect_now();
        exp_t e;
        int sat;
        sat = (1 << CNT_W) - 1;
        e = '0;
        if (!rst_n) begin
            mrem = 0;
            mcnt = 0;
        end else begin
            for (int i = 0; i < NSRC; i++)
                e.sh[2*i +: 2] = ref_fwd(Reg_E[i*N +: N]);
            e.cnt = CNT_W'(mcnt);
            if (mrem > 0) begin
                e.fe = 1;
                if (Flush_In) mrem = 0;
                else begin
                    e.sf = 1; e.sd = 1; mrem--;
                end
            end else if (Flush_In) begin
                e.fe = 1;
            end else if (ref_hit()) begin
                e.sf = 1; e.sd = 1; e.fe = 1;
                mrem = LOAD_LAT - 1;
            end
            if (Clr_Cnt) mcnt = 0;
            else if (e.sd && mcnt < sat) mcnt++;
        end
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        Reg_D = '0; Use_D = '0; Reg_E = '0; Rd_E = '0;
        We_E = 0; Ld_E = 0; Rd_M = '0; We_M = 0;
        Rd_WB = '0; We_WB = 0; Flush_In = 0; Clr_Cnt = 0;
    endtask

    task automatic hit5();
        idle_in();
        Ld_E = 1; We_E = 1; Rd_E = 4'd5;
        Reg_D = {4'd5, 4'd1}; Use_D = 2'b10;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick(); idle_in(); expect_now();
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("s_hazard", 32'(S_Hazard), 32'(e.sh));
                chk("stall_f", 32'(Stall_F), 32'(e.sf));
                chk("stall_d", 32'(Stall_D), 32'(e.sd));
                chk("flush_e", 32'(Flush_E), 32'(e.fe));
                chk("stall_cnt", 32'(Stall_Cnt), 32'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not complete");
            $fatal(1, "timeout");
        end
    end

    initial begin : driver
        idle_in();
        idle_cycles(2);
        tick(); rst_n = 1; idle_in(); expect_now();

        // forwarding priority
        tick(); idle_in();
        Reg_E = {4'd0, 4'd3}; Rd_M = 3; We_M = 1; Rd_WB = 3; We_WB = 1;
        expect_now();
        tick(); We_M = 0; expect_now();
        tick(); We_WB = 0; expect_now();

        // register 0 never forwards nor stalls
        tick(); idle_in();
        Reg_E = {4'd0, 4'd7}; Rd_M = 0; We_M = 1;
        Ld_E = 1; We_E = 1; Rd_E = 0; Use_D = 2'b11; Reg_D = '0;
        expect_now();

        // single load-use hit, then full stall
        tick(); idle_in(); Clr_Cnt = 1; expect_now();
        tick(); hit5(); expect_now();
        idle_cycles(4);

        // flush aborts on second stall cycle
        tick(); idle_in(); Clr_Cnt = 1; expect_now();
        tick(); hit5(); expect_now();
        tick(); idle_in(); Flush_In = 1; expect_now();
        idle_cycles(2);

        // flush beats hit in IDLE
        tick(); hit5(); Flush_In = 1; expect_now();
        idle_cycles(1);

        // asynchronous reset mid-stall
        tick(); hit5(); expect_now();
        tick(); idle_in(); rst_n = 0; expect_now();
        tick(); rst_n = 1; idle_in(); expect_now();
        idle_cycles(2);

        // saturation over 9 stall cycles, then clear while stalled
        tick(); idle_in(); Clr_Cnt = 1; expect_now();
        for (int h = 0; h < 3; h++) begin
            tick(); hit5(); expect_now();
            idle_cycles(2);
        end
        idle_cycles(1);
        tick(); hit5(); expect_now();
        tick(); idle_in(); Clr_Cnt = 1; expect_now();
        idle_cycles(2);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            tick();
            Reg_D = NSRC*N'($urandom_range(0, 255) & 8'h33);
            Use_D = NSRC'($urandom);
            Reg_E = NSRC*N'($urandom_range(0, 255) & 8'h33);
            Rd_E = N'($urandom_range(0, 3));
            We_E = ($urandom_range(0, 3) != 0);
            Ld_E = ($urandom_range(0, 1) != 0);
            Rd_M = N'($urandom_range(0, 3));
            We_M = ($urandom_range(0, 1) != 0);
            Rd_WB = N'($urandom_range(0, 3));
            We_WB = ($urandom_range(0, 1) != 0);
            Flush_In = ($urandom_range(0, 7) == 0);
            Clr_Cnt = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) rst_n = 0;
            else rst_n = 1;
            expect_now();
        end
        tick(); rst_n = 1; idle_in(); expect_now();

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
